shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter NBIT, default 8: word width in bits; legal range NBIT >= 2.
REQ-002 Parameter CW, default $clog2(NBIT): width of the bit counter.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port i_rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port i_s, input, 1: serial data bit.
REQ-006 Port i_s_valid, input, 1: i_s is sampled only in cycles where i_s_valid=1.
REQ-007 Port i_clr, input, 1: synchronous clear of the partial word and the overflow flag.
REQ-008 Port i_ready, input, 1: downstream accepts o_q in cycles where o_valid=1.
REQ-009 Port o_q, output, NBIT: last completed word (output buffer).
REQ-010 Port o_valid, output, 1: the output buffer holds an unconsumed word.
REQ-011 Port o_ovf, output, 1: sticky flag; a completed word was dropped.
REQ-012 Port o_busy, output, 1: a partial word is in progress (bit count != 0).
REQ-013 Port o_cnt, output, CW: number of bits received into the current partial word.

Function
REQ-014 Bit order is MSB first: each accepted bit shifts in as sr <= {sr[NBIT-2:0], i_s}, so after NBIT bits sr equals the transmitted word.
REQ-015 FSM states:
- IDLE: count = 0.
- RECV: 0 < count < NBIT.
REQ-016 FSM transitions:
- IDLE -> RECV on an accepted bit.
- RECV -> IDLE on the NBIT-th accepted bit.
- Any state -> IDLE on i_clr.
REQ-017 An accepted bit is i_s_valid=1 with i_clr=0; it increments o_cnt by 1.
REQ-018 o_cnt wraps from NBIT-1 to 0 on the NBIT-th bit; o_cnt never equals NBIT.
REQ-019 A word completes in the cycle of the NBIT-th accepted bit.
REQ-020 When a word completes and the output buffer is free, the word loads into o_q and o_valid=1 on the next edge (latency: 1 cycle after the last bit).
REQ-021 The output buffer is free when o_valid=0, or when o_valid=1 and i_ready=1 in the same cycle.
REQ-022 When a word completes and the output buffer is not free:
- The word is discarded.
- o_q is unchanged.
- o_ovf is set to 1 on the next edge.
REQ-023 A handshake (o_valid=1, i_ready=1) with no completing word clears o_valid on the next edge; o_q holds its last value.
REQ-024 A handshake in the same cycle as a completing word keeps o_valid=1 and loads the new word; no overflow occurs.
REQ-025 i_clr=1 has priority over i_s_valid:
- The bit in that cycle is discarded.
- o_cnt, the shift register and o_ovf go to 0.
- o_q and o_valid are unaffected; a handshake in the same cycle still completes.
REQ-026 o_ovf stays at 1 until i_clr or reset.
REQ-027 o_busy = (o_cnt != 0), driven combinationally from the counter.
REQ-028 i_ready is ignored while o_valid=0.
REQ-029 o_q is stable while o_valid=1 and i_ready=0.

Reset
REQ-030 When i_rstn=0, all state clears immediately, independent of i_clk:
- o_q = 0, o_valid = 0, o_ovf = 0, o_busy = 0, o_cnt = 0.
- Internal shift register = 0; FSM = IDLE.
REQ-031 Reset asserted mid-word discards the partial word; reception after deassertion starts at bit 0.
REQ-032 The first rising edge with i_rstn=1 is a normal operating edge.

Verification (NBIT=8)
REQ-033 Reset scenario: assert i_rstn=0 mid-stream, asynchronously to i_clk -> all outputs 0 immediately.
REQ-034 Back-to-back scenario: send 0xA5 MSB first with i_s_valid=1 for 8 consecutive cycles, i_ready=1 -> o_valid=1 and o_q=0xA5 one cycle after the 8th bit; o_valid=0 the next cycle.
REQ-035 Gapped-bit scenario: send 0x69 with i_s_valid pulsed on random cycles (gaps of 0-5 cycles) -> o_cnt steps only on valid bits; o_q=0x69; o_busy=1 from the 1st bit to the 8th bit.
REQ-036 Overflow scenario: i_ready=0, send 0x3C then 0xC3 -> o_q stays 0x3C, o_valid=1, o_ovf=1; then set i_ready=1 -> o_valid falls and o_ovf stays 1.
REQ-037 Simultaneous-event scenario: o_valid=1 holding 0x11 with i_ready=1 in the cycle of the 8th bit of 0x81 -> o_q=0x81, o_valid remains 1, o_ovf=0.
REQ-038 Clear scenario: send 3 bits, then i_clr=1 with i_s_valid=1 in the same cycle, then send 0x5A -> o_q=0x5A; o_cnt=0 after the clear; o_ovf=0.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// Serial-in / word-out handshake bundle for shift_deserializer.
interface shift_deserializer_if #(
  parameter int unsigned NBIT = 8,
  parameter int unsigned CW   = $clog2(NBIT)
);
  logic            i_s;
  logic            i_s_valid;
  logic            i_clr;
  logic            i_ready;
  logic [NBIT-1:0] o_q;
  logic            o_valid;
  logic            o_ovf;
  logic            o_busy;
  logic [CW-1:0]   o_cnt;

  // Upstream/downstream side: drives serial bits, clear and ready.
  modport master (
    output i_s, i_s_valid, i_clr, i_ready,
    input  o_q, o_valid, o_ovf, o_busy, o_cnt
  );

  // Deserializer side.
  modport slave (
    input  i_s, i_s_valid, i_clr, i_ready,
    output o_q, o_valid, o_ovf, o_busy, o_cnt
  );
endinterface

// File: rtl/shift_deserializer.sv
// MSB-first serial-to-parallel converter with a one-word output buffer,
// sticky overflow flag and synchronous clear.
module shift_deserializer #(
  parameter int unsigned NBIT = 8,
  parameter int unsigned CW   = $clog2(NBIT)
) (
  input logic               i_clk,
  input logic               i_rstn,
  shift_deserializer_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(NBIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NBIT-1:0] sr;
  logic [NBIT-1:0] sr_nxt;
  logic [NBIT-1:0] q;
  logic [NBIT-1:0] q_nxt;
  logic [NBIT-1:0] word;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            valid;
  logic            valid_nxt;
  logic            ovf;
  logic            ovf_nxt;
  logic            accept;
  logic            last_bit;
  logic            complete;
  logic            free;

  // Clear outranks a valid bit; a word completes on the NBIT-th accepted bit.
  assign accept   = bus.i_s_valid & ~bus.i_clr;
  assign last_bit = (state == RECV) && (cnt == LAST);
  assign complete = accept & last_bit;
  assign free     = ~valid | bus.i_ready;
  assign word     = {sr[NBIT-2:0], bus.i_s};

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE on clear or on the closing bit of a word.
  always_comb begin
    state_nxt = state;
    if (bus.i_clr) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    state_nxt = RECV;
        RECV:    state_nxt = last_bit ? IDLE : RECV;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath next values: shift register, counter, output buffer, overflow.
  always_comb begin
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    q_nxt     = q;
    valid_nxt = valid;
    ovf_nxt   = ovf;

    if (bus.i_clr) begin
      sr_nxt  = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (accept) begin
      sr_nxt  = word;
      cnt_nxt = last_bit ? '0 : cnt + CW'(1);
    end

    // Output buffer: load when free, otherwise drop and flag; else drain on handshake.
    if (complete && free) begin
      q_nxt     = word;
      valid_nxt = 1'b1;
    end else if (valid && bus.i_ready) begin
      valid_nxt = 1'b0;
    end

    if (complete && !free) begin
      ovf_nxt = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sr    <= '0;
      cnt   <= '0;
      q     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      valid <= valid_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign bus.o_q     = q;
  assign bus.o_valid = valid;
  assign bus.o_ovf   = ovf;
  assign bus.o_cnt   = cnt;
  assign bus.o_busy  = (cnt != '0);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer (NBIT = 8).
module tb_shift_deserializer;

  localparam int unsigned NBIT = 8;
  localparam int unsigned CW   = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shift_deserializer_if #(.NBIT(NBIT), .CW(CW)) bus ();

  shift_deserializer #(.NBIT(NBIT), .CW(CW)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // One accepted bit; returns 1 ns after the sampling edge.
  task automatic send_bit(input logic b);
    bus.i_s       = b;
    bus.i_s_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [NBIT-1:0] w);
    for (int i = NBIT - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_s = 1'b0; bus.i_s_valid = 1'b0; bus.i_clr = 1'b0; bus.i_ready = 1'b0;
    #1;
    checks++;
    if ({bus.o_q, bus.o_valid, bus.o_ovf, bus.o_busy, bus.o_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL reset_state: got q=%h v=%b ovf=%b busy=%b cnt=%0d, want all 0",
               bus.o_q, bus.o_valid, bus.o_ovf, bus.o_busy, bus.o_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [NBIT-1:0] w;
    w = 8'hA5;
    bus.i_ready = 1'b1;
    for (int i = NBIT - 1; i >= 0; i--) begin
      send_bit(w[i]);
      checks++;
      if (bus.o_cnt !== CW'((NBIT - i) % NBIT)) begin
        errors++;
        $display("FAIL b2b_cnt bit%0d: got %0d want %0d", NBIT - i, bus.o_cnt, (NBIT - i) % NBIT);
      end
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_q !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_word: got v=%b q=%h want v=1 q=a5", bus.o_valid, bus.o_q);
    end
    idle_cycle();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_q !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_drain: got v=%b q=%h want v=0 q=a5", bus.o_valid, bus.o_q);
    end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_gapped();
    logic [NBIT-1:0] w;
    int gaps [NBIT] = '{0, 3, 1, 5, 2, 0, 4, 1};
    w = 8'h69;
    for (int k = 0; k < NBIT; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        idle_cycle();
        checks++;
        if (bus.o_cnt !== CW'(k) || bus.o_busy !== (k != 0)) begin
          errors++;
          $display("FAIL gap_hold bit%0d: got cnt=%0d busy=%b want cnt=%0d", k, bus.o_cnt, bus.o_busy, k);
        end
      end
      send_bit(w[NBIT-1-k]);
      checks++;
      if (bus.o_cnt !== CW'((k + 1) % NBIT) || bus.o_busy !== (k + 1 < NBIT)) begin
        errors++;
        $display("FAIL gap_step bit%0d: got cnt=%0d busy=%b want cnt=%0d busy=%b",
                 k + 1, bus.o_cnt, bus.o_busy, (k + 1) % NBIT, (k + 1 < NBIT));
      end
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_q !== 8'h69) begin
      errors++;
      $display("FAIL gap_word: got v=%b q=%h want v=1 q=69", bus.o_valid, bus.o_q);
    end
    bus.i_ready = 1'b1;
    idle_cycle();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_overflow();
    send_word(8'h3C);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_q !== 8'h3C || bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: got v=%b q=%h ovf=%b want 1 3c 0", bus.o_valid, bus.o_q, bus.o_ovf);
    end
    send_word(8'hC3);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_q !== 8'h3C || bus.o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got v=%b q=%h ovf=%b want 1 3c 1", bus.o_valid, bus.o_q, bus.o_ovf);
    end
    bus.i_ready = 1'b1;
    idle_cycle();
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ovf !== 1'b1 || bus.o_q !== 8'h3C) begin
      errors++;
      $display("FAIL ovf_sticky: got v=%b ovf=%b q=%h want 0 1 3c", bus.o_valid, bus.o_ovf, bus.o_q);
    end
    bus.i_clr = 1'b1;
    idle_cycle();
    bus.i_clr = 1'b0;
    checks++;
    if (bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b want 0", bus.o_ovf);
    end
  endtask

  task automatic test_simultaneous();
    logic [NBIT-1:0] w;
    send_word(8'h11);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_q !== 8'h11) begin
      errors++;
      $display("FAIL sim_hold: got v=%b q=%h want v=1 q=11", bus.o_valid, bus.o_q);
    end
    w = 8'h81;
    for (int i = NBIT - 1; i >= 1; i--) send_bit(w[i]);
    checks++;
    if (bus.o_q !== 8'h11 || bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL sim_stable: got v=%b q=%h want v=1 q=11", bus.o_valid, bus.o_q);
    end
    bus.i_ready = 1'b1;
    send_bit(w[0]);
    checks++;
    if (bus.o_q !== 8'h81 || bus.o_valid !== 1'b1 || bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sim_swap: got q=%h v=%b ovf=%b want 81 1 0", bus.o_q, bus.o_valid, bus.o_ovf);
    end
    idle_cycle();
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL sim_drain: got v=%b want 0", bus.o_valid);
    end
  endtask

  task automatic test_clear();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++;
    if (bus.o_cnt !== 3'd3 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_partial: got cnt=%0d busy=%b want 3 1", bus.o_cnt, bus.o_busy);
    end
    bus.i_clr = 1'b1;
    send_bit(1'b1);
    bus.i_clr = 1'b0;
    checks++;
    if (bus.o_cnt !== 3'd0 || bus.o_busy !== 1'b0 || bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_cnt: got cnt=%0d busy=%b ovf=%b want 0 0 0", bus.o_cnt, bus.o_busy, bus.o_ovf);
    end
    send_word(8'h5A);
    checks++;
    if (bus.o_q !== 8'h5A || bus.o_valid !== 1'b1 || bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_word: got q=%h v=%b ovf=%b want 5a 1 0", bus.o_q, bus.o_valid, bus.o_ovf);
    end
    bus.i_clr   = 1'b1;
    bus.i_ready = 1'b1;
    idle_cycle();
    bus.i_clr   = 1'b0;
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_q !== 8'h5A) begin
      errors++;
      $display("FAIL clr_handshake: got v=%b q=%h want 0 5a", bus.o_valid, bus.o_q);
    end
  endtask

  task automatic test_async_reset();
    send_word(8'hF0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus.i_s_valid = 1'b1;
    bus.i_s       = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_q, bus.o_valid, bus.o_ovf, bus.o_busy, bus.o_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL async_reset: got q=%h v=%b ovf=%b busy=%b cnt=%0d, want all 0",
               bus.o_q, bus.o_valid, bus.o_ovf, bus.o_busy, bus.o_cnt);
    end
    bus.i_s_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    send_word(8'hA5);
    checks++;
    if (bus.o_q !== 8'hA5 || bus.o_valid !== 1'b1 || bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_word: got q=%h v=%b ovf=%b want a5 1 0", bus.o_q, bus.o_valid, bus.o_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_overflow();
    test_simultaneous();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
